// File: rtl/gpio_edge_scan_ctrl_if.sv
// Bus bundle for gpio_edge_scan_ctrl: the Avalon-MM master lines towards the
// edge-capture PIO and the valid/ready event stream towards the consumer.
interface gpio_edge_scan_ctrl_if #(
  parameter int DATA_W = 4
) ();
  logic [1:0]        pio_address;
  logic              pio_chipselect;
  logic              pio_write_n;
  logic [31:0]       pio_writedata;
  logic [31:0]       pio_readdata;

  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_edges;
  logic [DATA_W-1:0] evt_level;

  // Scanner side: drives the PIO bus and sources events.
  modport master (
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata,
    input  pio_readdata,
    output evt_valid,
    output evt_edges,
    output evt_level,
    input  evt_ready
  );

  // PIO/consumer side.
  modport slave (
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata,
    output pio_readdata,
    input  evt_valid,
    input  evt_edges,
    input  evt_level,
    output evt_ready
  );
endinterface

// File: rtl/gpio_edge_scan_ctrl.sv
// gpio_edge_scan_ctrl: autonomous poller for a 4-bit edge-capture PIO.
// Every poll period it reads the edge-capture register; when any edge is
// pending it clears the register, reads the pin levels and queues
// {edges, level} in a small show-ahead event FIFO.
module gpio_edge_scan_ctrl #(
  parameter int DATA_W     = 4,
  parameter int POLL_DIV   = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  gpio_edge_scan_ctrl_if.master bus,
  output logic                  evt_overflow,
  input  logic                  overflow_clr
);

  localparam int              CNT_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW + 1)'(1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_CAP,
    WAIT_CAP,
    CLR,
    RD_DAT,
    WAIT_DAT,
    PUSH
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  poll_cnt;

  logic [DATA_W-1:0] cap_edges_p0;
  logic [DATA_W-1:0] cap_level_p0;

  logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;

  // Only the low DATA_W bits of readdata carry pin information.
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.pio_readdata[31:DATA_W];

  // Scan sequencer: poll countdown plus the PIO access sequence, with all bus
  // outputs registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      poll_cnt           <= RELOAD;
      bus.pio_address    <= ADDR_LEVEL;
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;
      bus.pio_writedata  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          bus.pio_address    <= ADDR_LEVEL;
          bus.pio_chipselect <= 1'b0;
          bus.pio_write_n    <= 1'b1;
          if (enable) begin
            if (poll_cnt == '0) begin
              state              <= RD_CAP;
              poll_cnt           <= RELOAD;
              bus.pio_address    <= ADDR_EDGE;
              bus.pio_chipselect <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt - CNT_ONE;
            end
          end
        end
        RD_CAP: begin
          state              <= WAIT_CAP;
          bus.pio_chipselect <= 1'b0;
        end
        WAIT_CAP: begin
          if (bus.pio_readdata[DATA_W-1:0] == '0) begin
            state           <= IDLE;
            bus.pio_address <= ADDR_LEVEL;
          end else begin
            // Any write to the edge register clears every captured bit.
            state              <= CLR;
            bus.pio_chipselect <= 1'b1;
            bus.pio_write_n    <= 1'b0;
            bus.pio_writedata  <= 32'hFFFF_FFFF;
          end
        end
        CLR: begin
          state              <= RD_DAT;
          bus.pio_address    <= ADDR_LEVEL;
          bus.pio_chipselect <= 1'b1;
          bus.pio_write_n    <= 1'b1;
          bus.pio_writedata  <= 32'h0000_0000;
        end
        RD_DAT: begin
          state              <= WAIT_DAT;
          bus.pio_chipselect <= 1'b0;
        end
        WAIT_DAT: begin
          state <= PUSH;
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state              <= IDLE;
          bus.pio_address    <= ADDR_LEVEL;
          bus.pio_chipselect <= 1'b0;
          bus.pio_write_n    <= 1'b1;
          bus.pio_writedata  <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Capture stage: readdata is valid the cycle after the read address.
  always_ff @(posedge clk) begin
    if (state == WAIT_CAP) begin
      cap_edges_p0 <= bus.pio_readdata[DATA_W-1:0];
    end
    if (state == WAIT_DAT) begin
      cap_level_p0 <= bus.pio_readdata[DATA_W-1:0];
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && bus.evt_ready;
  assign push_req   = (state == PUSH);
  // A pop in the same cycle frees the slot the push needs.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // Event storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {cap_edges_p0, cap_level_p0};
    end
  end

  // FIFO pointers: one extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      evt_overflow <= 1'b0;
    end else if (drop) begin
      evt_overflow <= 1'b1;
    end else if (overflow_clr) begin
      evt_overflow <= 1'b0;
    end
  end

  assign bus.evt_valid                  = !fifo_empty;
  assign {bus.evt_edges, bus.evt_level} = fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_gpio_edge_scan_ctrl.sv
// Directed bench for gpio_edge_scan_ctrl with a behavioural edge-capture PIO.
module tb_gpio_edge_scan_ctrl;

  localparam int DATA_W     = 4;
  localparam int POLL_DIV   = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic evt_overflow;
  logic overflow_clr;

  gpio_edge_scan_ctrl_if #(.DATA_W(DATA_W)) bus ();

  gpio_edge_scan_ctrl #(
    .DATA_W(DATA_W),
    .POLL_DIV(POLL_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .bus(bus),
    .evt_overflow(evt_overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // PIO model: edge register ORs in injected edges, any write clears it;
  // readdata is registered and carries junk in the unused upper bits.
  logic [3:0] inj = 4'h0;
  logic [3:0] level = 4'h0;
  logic [3:0] edge_cap = 4'h0;

  always @(posedge clk) begin
    if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'd3)
      edge_cap <= 4'h0;
    else
      edge_cap <= edge_cap | inj;
    if (bus.pio_chipselect && bus.pio_write_n)
      bus.pio_readdata <= (bus.pio_address == 2'd3) ? {28'hABCDEF0, edge_cap}
                                                    : {28'h1234560, level};
  end

  // Bus activity monitor.
  int cyc = 0;
  int wr_cnt = 0;
  int rd3_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.pio_chipselect && !bus.pio_write_n) wr_cnt <= wr_cnt + 1;
    if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3)
      rd3_cnt <= rd3_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdcap(input int budget, output int t);
    bit found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect && bus.pio_write_n && bus.pio_address == 2'd3) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("rdcap_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_clr(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.pio_chipselect && !bus.pio_write_n) found = 1'b1;
    end
    check("clr_seen", {31'd0, found}, 32'd1);
  endtask

  // Inject edges, then stop at the negedge inside the PUSH cycle.
  task automatic run_to_push(input logic [3:0] e, input logic [3:0] l);
    level = l;
    inj = e;
    @(negedge clk);
    inj = 4'h0;
    wait_clr(40);
    repeat (3) @(negedge clk);
  endtask

  logic [3:0] t4_e [5] = '{4'h1, 4'h2, 4'h8, 4'hF, 4'h6};
  logic [3:0] t4_l [5] = '{4'hA, 4'h5, 4'h0, 4'hF, 4'h3};
  logic [3:0] t5_e [5] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
  logic [3:0] t5_l [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, ts, snap;
    reset_n = 1'b0;
    enable = 1'b0;
    overflow_clr = 1'b0;
    bus.evt_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_cs", bus.pio_chipselect, 1'b0);
    check("rst_wn", bus.pio_write_n, 1'b1);
    check("rst_addr", bus.pio_address, 2'd0);
    check("rst_wdata", bus.pio_writedata, 32'h0);
    check("rst_valid", bus.evt_valid, 1'b0);
    check("rst_ovf", evt_overflow, 1'b0);

    // Empty polls: 8 idle countdown cycles, then a 2-cycle empty scan.
    reset_n = 1'b1;
    enable = 1'b1;
    ts = cyc;
    wait_rdcap(40, t0);
    check("first_poll_delay", t0 - ts, 8);
    @(negedge clk);
    check("waitcap_addr", bus.pio_address, 2'd3);
    check("waitcap_cs", bus.pio_chipselect, 1'b0);
    wait_rdcap(40, t1);
    check("empty_poll_period", t1 - t0, POLL_DIV + 2);
    check("empty_no_write", wr_cnt, 0);
    check("empty_valid", bus.evt_valid, 1'b0);
    repeat (2) @(negedge clk);

    // Single event, cycle by cycle from RD_CAP.
    level = 4'b0100;
    inj = 4'b0101;
    @(negedge clk);
    inj = 4'h0;
    wait_rdcap(40, t0);
    @(negedge clk);
    check("ev_c1_addr", bus.pio_address, 2'd3);
    check("ev_c1_cs", bus.pio_chipselect, 1'b0);
    @(negedge clk);
    check("ev_c2_cs", bus.pio_chipselect, 1'b1);
    check("ev_c2_wn", bus.pio_write_n, 1'b0);
    check("ev_c2_addr", bus.pio_address, 2'd3);
    check("ev_c2_wdata", bus.pio_writedata, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ev_c3_cs", bus.pio_chipselect, 1'b1);
    check("ev_c3_wn", bus.pio_write_n, 1'b1);
    check("ev_c3_addr", bus.pio_address, 2'd0);
    @(negedge clk);
    check("ev_c4_cs", bus.pio_chipselect, 1'b0);
    @(negedge clk);
    check("ev_c5_valid", bus.evt_valid, 1'b0);
    @(negedge clk);
    check("ev_c6_valid", bus.evt_valid, 1'b1);
    check("ev_c6_edges", bus.evt_edges, 4'b0101);
    check("ev_c6_level", bus.evt_level, 4'b0100);
    check("ev_one_write", wr_cnt, 1);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    check("ev_popped", bus.evt_valid, 1'b0);

    // Overflow: five events with no consumer.
    for (int i = 0; i < 5; i++) begin
      run_to_push(t4_e[i], t4_l[i]);
      if (i == 4) overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      if (i == 3) check("ovf_after4", evt_overflow, 1'b0);
    end
    check("ovf_set_beats_clr", evt_overflow, 1'b1);
    check("ovf_head_edges", bus.evt_edges, t4_e[0]);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_cleared", evt_overflow, 1'b0);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain4_edges%0d", i), bus.evt_edges, t4_e[i]);
      check($sformatf("drain4_level%0d", i), bus.evt_level, t4_l[i]);
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    check("drain4_empty", bus.evt_valid, 1'b0);

    // Full FIFO with a pop in the PUSH cycle: no drop.
    for (int i = 0; i < 4; i++) begin
      run_to_push(t5_e[i], t5_l[i]);
      @(negedge clk);
    end
    run_to_push(t5_e[4], t5_l[4]);
    check("full_head", bus.evt_edges, t5_e[0]);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    check("full_pop_no_ovf", evt_overflow, 1'b0);
    bus.evt_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain5_edges%0d", i), bus.evt_edges, t5_e[i]);
      check($sformatf("drain5_level%0d", i), bus.evt_level, t5_l[i]);
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    check("drain5_empty", bus.evt_valid, 1'b0);

    // enable dropped during CLR: the scan still completes.
    level = 4'hE;
    inj = 4'h3;
    @(negedge clk);
    inj = 4'h0;
    wait_clr(40);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("en_off_valid", bus.evt_valid, 1'b1);
    check("en_off_edges", bus.evt_edges, 4'h3);
    check("en_off_level", bus.evt_level, 4'hE);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    snap = rd3_cnt;
    repeat (20) @(negedge clk);
    check("en_off_no_poll", rd3_cnt, snap);
    enable = 1'b1;
    ts = cyc;
    wait_rdcap(40, t0);
    check("en_on_full_count", t0 - ts, 8);
    repeat (2) @(negedge clk);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    snap = rd3_cnt;
    repeat (10) @(negedge clk);
    check("en_hold_no_poll", rd3_cnt, snap);
    enable = 1'b1;
    ts = cyc;
    wait_rdcap(40, t0);
    check("en_resume_held", t0 - ts, 5);

    // Reset asserted in a PUSH that would overflow a full FIFO.
    for (int i = 0; i < 4; i++) begin
      run_to_push(t4_e[i], t4_l[i]);
      @(negedge clk);
    end
    run_to_push(4'h5, 4'h9);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_cs", bus.pio_chipselect, 1'b0);
    check("rst2_wn", bus.pio_write_n, 1'b1);
    check("rst2_addr", bus.pio_address, 2'd0);
    check("rst2_valid", bus.evt_valid, 1'b0);
    check("rst2_ovf", evt_overflow, 1'b0);
    reset_n = 1'b1;
    ts = cyc;
    wait_rdcap(40, t0);
    check("rst2_reload", t0 - ts, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
